bfly_combine: RTL and testbench
===============================

# bfly_combine

Butterfly combine stage that sits directly downstream of the constant twiddle multiplier in the butterfly datapath. Each cycle it can accept a direct operand `a`, launched in the same cycle that the paired operand `b` enters the multiplier. It delays `a` and its valid bit to line up with the multiplier result `wb`, then produces a registered saturating sum `a + wb` and difference `a - wb`. It also counts output pairs per frame and keeps a sticky saturation flag for the control logic.

## Interface
- `N`, default 4: datapath width is 2**N bits (16 by default), matching the multiplier.
- `FRAME_LOG2`, default 3: frame length is 2**FRAME_LOG2 output pairs.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: `a` is valid this cycle, and its paired `b` is entering the multiplier this cycle.
- `a` in 2**N: direct (unmultiplied) operand, unsigned.
- `wb` in 2**N: multiplier result, unsigned; valid 2 cycles after its `b` was applied.
- `sat_clr` in 1: clears `sat_sticky`.
- `out_valid` out 1: `sum`, `diff`, `frame_idx` and `frame_last` are valid.
- `sum` out 2**N: saturated `a + wb`.
- `diff` out 2**N: clamped `a - wb`.
- `frame_idx` out FRAME_LOG2: index of the current output within its frame.
- `frame_last` out 1: this output is the last of its frame.
- `sat_sticky` out 1: a saturation or clamp has occurred since the last clear or reset.

## Operation
- **Alignment:**
  - A 2-stage delay line holds `a` and `in_valid`: stage d1, then d2.
  - The multiplier result for the pair launched at cycle t is present on `wb` during cycle t+2, which is the same cycle d2 holds `a`.
  - The delay line runs every cycle; there are no stalls and no enable, because the multiplier is free-running.
- **Arithmetic** (performed on d2 and `wb`, unsigned, computed at width 2**N+1):
  - `sum` = `a + wb`. If the carry-out is set, `sum` = all ones and a saturation event is raised.
  - `diff` = `a - wb`. If `wb > a`, `diff` = 0 and a saturation event is raised.
  - When `wb` equals `a`, `diff` = 0 and no saturation event is raised.
- **Output register:**
  - `sum`, `diff` and `out_valid` load every cycle from stage d2.
  - When the d2 valid bit is 0, `out_valid` = 0 and `sum`/`diff` hold their previous values.
- **Frame counter:**
  - Increments on each `out_valid` output and wraps at 2**FRAME_LOG2-1 → 0.
  - `frame_idx` is the count value attached to the current output.
  - `frame_last` = `out_valid` && `frame_idx` == 2**FRAME_LOG2-1; it is a single-cycle pulse.
- **sat_sticky:**
  - Set on any saturation event of a valid output.
  - Cleared when `sat_clr` = 1.
  - If a saturation event and `sat_clr` occur in the same cycle, set wins.
  - Events on invalid (bubble) slots are ignored.

## Timing
- Latency is 3 cycles: `in_valid`/`a` at cycle t give `out_valid`/`sum`/`diff` at cycle t+3.
- Throughput is one pair per cycle. Bubbles in `in_valid` are preserved exactly at the output.
- **Reset values:**
  - `out_valid` = 0, `sum` = 0, `diff` = 0, `frame_idx` = 0, `frame_last` = 0, `sat_sticky` = 0.
  - d1/d2 valid bits = 0, d1/d2 data = 0.
- **Reset mid-stream:**
  - In-flight pairs are discarded: no `out_valid` for 3 cycles after reset is released, unless new inputs arrive.
  - The frame counter restarts at 0.
  - The multiplier is reset by the same `rst`, so `wb` alignment is preserved.
- **Simultaneous `in_valid` and `rst`:** reset wins and the input is dropped.
- **Frame wrap:**
  - The pair after `frame_last` has `frame_idx` = 0.
  - Bubbles do not advance the counter.

## Test plan
- **Single pair:** `a`=0x4000 and `b`=0x2000 into the multiplier (so `wb`=0x16A0) at cycle 0, after reset → at cycle 3 `out_valid`=1, `sum`=0x56A0, `diff`=0x2960, `sat_sticky`=0; `out_valid`=0 at cycles 1, 2 and 4.
- **Saturation:** `a`=0xF000, `b`=0x4000 (`wb`=0x2D40) → `sum`=0xFFFF, `diff`=0xC2C0, `sat_sticky`=1. Then `a`=0x1000, `b`=0x2000 (`wb`=0x16A0) → `diff`=0x0000, `sum`=0x26A0. Then pulse `sat_clr` with no event → `sat_sticky`=0.
- **Streaming:** 10 back-to-back valid pairs → 10 consecutive `out_valid` cycles starting at cycle 3; `frame_idx` runs 0..7 then 0, 1; `frame_last` is high only on the 8th output.
- **Bubbles:** `in_valid` pattern 1,0,1,1,0,1 → the identical pattern on `out_valid` shifted by 3; `frame_idx` advances only on valid outputs; `sum` holds during bubbles.
- **Reset mid-stream:** assert `rst` for 1 cycle while 2 pairs are in flight → neither pair appears at the output; all outputs are 0 the cycle after reset; the next valid pair emerges with `frame_idx`=0.
- **Same-cycle clear:** a saturating pair arrives at the output in the same cycle `sat_clr`=1 → `sat_sticky`=1 on the following cycle.

Source files
------------

// File: rtl/bfly_combine.sv
// bfly_combine: aligns a with the multiplier result and emits saturating sum/diff per frame
module bfly_combine #(
   parameter int N          = 4,
   parameter int FRAME_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [2**N-1:0]       a,
   input  logic [2**N-1:0]       wb,
   input  logic                  sat_clr,
   output logic                  out_valid,
   output logic [2**N-1:0]       sum,
   output logic [2**N-1:0]       diff,
   output logic [FRAME_LOG2-1:0] frame_idx,
   output logic                  frame_last,
   output logic                  sat_sticky
);
   localparam int W = 2**N;
   logic            d1_v, d2_v;
   logic [W-1:0]    d1_a, d2_a;
   logic [W:0]      add_w, sub_w;
   logic            sat_add, sat_sub, sat_evt;
   logic [W-1:0]    sum_n, diff_n;
   logic [FRAME_LOG2-1:0] cnt;
   // one-bit-wider arithmetic: bit W is the carry of the add and the borrow of the subtract
   always_comb begin
      add_w   = {1'b0, d2_a} + {1'b0, wb};
      sub_w   = {1'b0, d2_a} - {1'b0, wb};
      sat_add = add_w[W];
      sat_sub = sub_w[W];
      sum_n   = sat_add ? '1 : add_w[W-1:0];
      diff_n  = sat_sub ? '0 : sub_w[W-1:0];
      sat_evt = d2_v && (sat_add || sat_sub);
   end
   // free-running two-stage delay so a meets wb from the two-cycle multiplier
   always_ff @(posedge clk) begin
      if (rst) begin
         d1_v <= 1'b0;
         d2_v <= 1'b0;
         d1_a <= '0;
         d2_a <= '0;
      end else begin
         d1_v <= in_valid;
         d2_v <= d1_v;
         d1_a <= a;
         d2_a <= d1_a;
      end
   end
   // output register; data holds across bubbles so only valid results are ever shown
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         diff      <= '0;
      end else begin
         out_valid <= d2_v;
         sum       <= d2_v ? sum_n : sum;
         diff      <= d2_v ? diff_n : diff;
      end
   end
   // cnt is the index the next valid output will carry; it wraps naturally at its width
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         frame_idx <= '0;
      end else if (d2_v) begin
         cnt       <= cnt + 1'b1;
         frame_idx <= cnt;
      end
   end
   // sticky flag: a saturation on a valid slot beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (rst) sat_sticky <= 1'b0;
      else     sat_sticky <= sat_evt ? 1'b1 : (sat_clr ? 1'b0 : sat_sticky);
   end
   assign frame_last = out_valid && (&frame_idx);
endmodule

// File: tb/tb_bfly_combine.sv
// tb_bfly_combine: directed-vector bench for bfly_combine, driving wb two cycles after each a
module tb_bfly_combine;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] wb = '0;
   logic        sat_clr = 1'b0;
   logic        out_valid;
   logic [15:0] sum, diff;
   logic [2:0]  frame_idx;
   logic        frame_last, sat_sticky;
   logic [15:0] wq [2];
   int nvec = 0;
   int nerr = 0;

   bfly_combine #(.N(4), .FRAME_LOG2(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .wb(wb), .sat_clr(sat_clr),
      .out_valid(out_valid), .sum(sum), .diff(diff), .frame_idx(frame_idx),
      .frame_last(frame_last), .sat_sticky(sat_sticky)
   );

   always #5 clk = ~clk;

   // drive one cycle of input; wv is the multiplier result presented two cycles later
   task automatic step(input logic iv, input logic [15:0] av, input logic [15:0] wv);
      wb       = wq[1];
      wq[1]    = wq[0];
      wq[0]    = wv;
      in_valid = iv;
      a        = av;
      @(posedge clk);
      #1;
      if (rst) begin
         wq[0] = '0;
         wq[1] = '0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 16'h0, 16'h0);
      step(1'b0, 16'h0, 16'h0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      nvec++; if ({out_valid, frame_last, sat_sticky} !== 3'b000) begin nerr++; $display("FAIL reset_flags got %b want 000", {out_valid, frame_last, sat_sticky}); end
      nvec++; if ({sum, diff} !== 32'h0) begin nerr++; $display("FAIL reset_data got %h want 0", {sum, diff}); end
      nvec++; if (frame_idx !== 3'd0) begin nerr++; $display("FAIL reset_idx got %0d want 0", frame_idx); end
   endtask

   task automatic test_single();
      step(1'b1, 16'h4000, 16'h16A0);
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL single_c1 got %b want 0", out_valid); end
      step(1'b0, 16'h0, 16'h0);
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL single_c2 got %b want 0", out_valid); end
      step(1'b0, 16'h0, 16'h0);
      nvec++; if ({out_valid, sum, diff, sat_sticky} !== {1'b1, 16'h56A0, 16'h2960, 1'b0}) begin nerr++; $display("FAIL single_c3 got v=%b s=%h d=%h st=%b want 1 56a0 2960 0", out_valid, sum, diff, sat_sticky); end
      nvec++; if (frame_idx !== 3'd0) begin nerr++; $display("FAIL single_idx got %0d want 0", frame_idx); end
      step(1'b0, 16'h0, 16'h0);
      nvec++; if ({out_valid, sum} !== {1'b0, 16'h56A0}) begin nerr++; $display("FAIL single_c4 got v=%b s=%h want 0 56a0", out_valid, sum); end
   endtask

   task automatic test_saturation();
      step(1'b1, 16'hF000, 16'h2D40);
      step(1'b1, 16'h1000, 16'h16A0);
      step(1'b0, 16'h0, 16'h0);
      nvec++; if ({out_valid, sum, diff, sat_sticky} !== {1'b1, 16'hFFFF, 16'hC2C0, 1'b1}) begin nerr++; $display("FAIL sat_add got v=%b s=%h d=%h st=%b want 1 ffff c2c0 1", out_valid, sum, diff, sat_sticky); end
      nvec++; if (frame_idx !== 3'd1) begin nerr++; $display("FAIL sat_idx got %0d want 1", frame_idx); end
      step(1'b0, 16'h0, 16'h0);
      nvec++; if ({out_valid, sum, diff, sat_sticky} !== {1'b1, 16'h26A0, 16'h0000, 1'b1}) begin nerr++; $display("FAIL sat_sub got v=%b s=%h d=%h st=%b want 1 26a0 0000 1", out_valid, sum, diff, sat_sticky); end
      step(1'b0, 16'h0, 16'h0);
      nvec++; if (sat_sticky !== 1'b1) begin nerr++; $display("FAIL sat_hold got %b want 1", sat_sticky); end
      sat_clr = 1'b1;
      step(1'b0, 16'h0, 16'h0);
      sat_clr = 1'b0;
      nvec++; if (sat_sticky !== 1'b0) begin nerr++; $display("FAIL sat_clr got %b want 0", sat_sticky); end
   endtask

   task automatic test_edges();
      do_reset();
      step(1'b1, 16'h1234, 16'h1234);
      step(1'b1, 16'h8000, 16'h7FFF);
      step(1'b0, 16'h0, 16'h0);
      nvec++; if ({out_valid, sum, diff, sat_sticky} !== {1'b1, 16'h2468, 16'h0000, 1'b0}) begin nerr++; $display("FAIL edge_equal got v=%b s=%h d=%h st=%b want 1 2468 0000 0", out_valid, sum, diff, sat_sticky); end
      step(1'b0, 16'h0, 16'h0);
      nvec++; if ({out_valid, sum, diff, sat_sticky} !== {1'b1, 16'hFFFF, 16'h0001, 1'b0}) begin nerr++; $display("FAIL edge_full got v=%b s=%h d=%h st=%b want 1 ffff 0001 0", out_valid, sum, diff, sat_sticky); end
   endtask

   task automatic test_back_to_back();
      int k;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         step(i < 10, 16'(16'h0100 * (i + 1)), 16'(16'h0010 * (i + 1)));
         if (i >= 2) begin
            k = i - 2;
            nvec++;
            if (k < 10) begin
               if ({out_valid, frame_idx, frame_last, sum, diff} !== {1'b1, 3'(k % 8), k == 7, 16'(16'h0110 * (k + 1)), 16'(16'h00F0 * (k + 1))}) begin
                  nerr++; $display("FAIL stream_%0d got v=%b i=%0d l=%b s=%h d=%h want 1 %0d %b %h %h", k, out_valid, frame_idx, frame_last, sum, diff, k % 8, k == 7, 16'(16'h0110 * (k + 1)), 16'(16'h00F0 * (k + 1)));
               end
            end else if ({out_valid, frame_last} !== 2'b00) begin
               nerr++; $display("FAIL stream_tail_%0d got v=%b l=%b want 0 0", k, out_valid, frame_last);
            end
         end
      end
   endtask

   task automatic test_bubbles();
      logic [8:0]  pat = 9'b000_101101;
      logic [2:0]  eidx = '0;
      logic [15:0] esum = '0;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(pat[i], 16'(16'h0100 * (i + 1)), 16'h0001);
         if (i >= 2) begin
            if (pat[i-2]) begin
               esum = 16'(16'h0100 * (i - 1) + 1);
               nvec++;
               if ({out_valid, frame_idx, sum} !== {1'b1, eidx, esum}) begin
                  nerr++; $display("FAIL bubble_%0d got v=%b i=%0d s=%h want 1 %0d %h", i - 2, out_valid, frame_idx, sum, eidx, esum);
               end
               eidx = eidx + 1'b1;
            end else begin
               nvec++;
               if ({out_valid, sum} !== {1'b0, esum}) begin
                  nerr++; $display("FAIL bubble_%0d got v=%b s=%h want 0 %h", i - 2, out_valid, sum, esum);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1'b1, 16'h0300, 16'h0100);
      step(1'b0, 16'h0, 16'h0);
      step(1'b0, 16'h0, 16'h0);
      nvec++; if ({out_valid, frame_idx} !== {1'b1, 3'd0}) begin nerr++; $display("FAIL mid_pre got v=%b i=%0d want 1 0", out_valid, frame_idx); end
      step(1'b1, 16'hF000, 16'hF000);
      step(1'b1, 16'hE000, 16'hE000);
      rst = 1'b1;
      step(1'b1, 16'h7777, 16'hFFFF);
      rst = 1'b0;
      nvec++; if ({out_valid, sum, diff, frame_idx, frame_last, sat_sticky} !== 38'h0) begin nerr++; $display("FAIL mid_zero got v=%b s=%h d=%h i=%0d l=%b st=%b want all 0", out_valid, sum, diff, frame_idx, frame_last, sat_sticky); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 16'h0, 16'h0);
         nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_quiet_%0d got %b want 0", i, out_valid); end
      end
      step(1'b1, 16'h0200, 16'h0100);
      step(1'b0, 16'h0, 16'h0);
      step(1'b0, 16'h0, 16'h0);
      nvec++; if ({out_valid, frame_idx, sum, diff} !== {1'b1, 3'd0, 16'h0300, 16'h0100}) begin nerr++; $display("FAIL mid_next got v=%b i=%0d s=%h d=%h want 1 0 0300 0100", out_valid, frame_idx, sum, diff); end
   endtask

   task automatic test_same_cycle_clear();
      do_reset();
      step(1'b1, 16'hFFFF, 16'h0001);
      step(1'b0, 16'h0, 16'h0);
      sat_clr = 1'b1;
      step(1'b0, 16'h0, 16'h0);
      nvec++; if ({out_valid, sum, sat_sticky} !== {1'b1, 16'hFFFF, 1'b1}) begin nerr++; $display("FAIL clr_race got v=%b s=%h st=%b want 1 ffff 1", out_valid, sum, sat_sticky); end
      step(1'b0, 16'h0, 16'h0);
      sat_clr = 1'b0;
      nvec++; if (sat_sticky !== 1'b0) begin nerr++; $display("FAIL clr_after got %b want 0", sat_sticky); end
   endtask

   initial begin
      wq[0] = '0;
      wq[1] = '0;
      test_reset();
      test_single();
      test_saturation();
      test_edges();
      test_back_to_back();
      test_bubbles();
      test_reset_mid();
      test_same_cycle_clear();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
